// File: rtl/count_monitor.sv
// Classifies successive 4-bit counter samples into WRAP/JUMP/RESTART events and queues them in a FIFO (1-cycle latency).
// Consumer backpressure via evt_ready; a full FIFO with no pop drops the new event and sets sticky overflow.
module count_monitor #(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cnt_in,
  input  logic              cnt_valid,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_type,
  output logic [3:0]        evt_cnt,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [1:0] EVT_WRAP    = 2'b01;
  localparam logic [1:0] EVT_JUMP    = 2'b10;
  localparam logic [1:0] EVT_RESTART = 2'b11;

  logic [3:0]        r_prev_cnt;
  logic              r_prev_ok;
  logic [1:0]        r_mem_type [DEPTH];
  logic [3:0]        r_mem_cnt  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_occ;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              r_overflow;

  logic       w_hold;
  logic       w_step;
  logic       w_wrap;
  logic       w_restart;
  logic       w_evt;
  logic [1:0] w_evt_type;
  logic       w_full;
  logic       w_pop;
  logic       w_push;

  // prev+1 overflows to 0 when prev is 15, so STEP must exclude that case explicitly
  always_comb begin
    w_hold     = (cnt_in == r_prev_cnt);
    w_step     = (r_prev_cnt != 4'hF) && (cnt_in == r_prev_cnt + 4'd1);
    w_wrap     = (r_prev_cnt == 4'hF) && (cnt_in == 4'h0);
    w_restart  = (r_prev_cnt != 4'hF) && (cnt_in == 4'h0);
    w_evt      = cnt_valid && r_prev_ok && !w_hold && !w_step;
    w_evt_type = w_wrap ? EVT_WRAP : (w_restart ? EVT_RESTART : EVT_JUMP);
  end

  always_comb begin
    evt_valid  = (r_occ != '0);
    evt_type   = evt_valid ? r_mem_type[r_rd_ptr] : 2'b00;
    evt_cnt    = evt_valid ? r_mem_cnt[r_rd_ptr]  : 4'h0;
    wrap_count = r_wrap_count;
    overflow   = r_overflow;
    w_full     = (r_occ == OCC_FULL);
    w_pop      = evt_valid && evt_ready;
    w_push     = w_evt && (!w_full || w_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_cnt <= 4'h0;
      r_prev_ok  <= 1'b0;
    end else if (cnt_valid) begin
      r_prev_cnt <= cnt_in;
      r_prev_ok  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_occ
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_type[r_wr_ptr] <= w_evt_type;
      r_mem_cnt[r_wr_ptr]  <= cnt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_evt && w_wrap && (r_wrap_count != '1)) r_wrap_count <= r_wrap_count + WRAP_ONE;
      if (w_evt && !w_push) r_overflow <= 1'b1;
    end
  end
endmodule
